// File: rtl/mem_ss_cal_pkg.sv
// Shared types for the memory-subsystem reset and EMIF calibration sequencer.
// Holds the FSM state encoding, error codes and the CSR status layout.
package mem_ss_cal_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_REQ,
        S_WAIT_CAL,
        S_RETRY,
        S_DONE,
        S_ERR
    } t_cal_state;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_ACK  = 2'd1;
    localparam logic [1:0] ERR_CAL  = 2'd2;
    localparam logic [1:0] ERR_LOST = 2'd3;

    typedef struct packed {
        logic       busy;
        logic       seq_done;
        logic       seq_err;
        logic [1:0] err_code;
        logic [1:0] retry_cnt;
    } t_cal_status;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/mem_ss_cal_ch_filter.sv
// Per-channel calibration qualifier: counts consecutive clean pass cycles
// and flags the channel done once the run reaches STABLE_CYC.
module mem_ss_cal_ch_filter #(
    parameter int STABLE_CYC = 3,
    parameter bit IGNORE     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic cal_success,
    input  logic cal_fail,
    output logic done,
    output logic fail
);

    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam logic [SW-1:0] LIM = SW'(STABLE_CYC);

    logic [SW-1:0] cnt;
    logic [SW-1:0] cnt_nxt;
    logic          good;

    assign good = cal_success & ~cal_fail;

    always_comb begin
        cnt_nxt = '0;
        if (good)
            cnt_nxt = (cnt == LIM) ? cnt : cnt + SW'(1);
    end

    // Ignored channels report done as soon as qualification runs.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (en) begin
            cnt  <= cnt_nxt;
            done <= IGNORE ? 1'b1 : (cnt_nxt == LIM);
        end
    end

    assign fail = en & ~IGNORE & cal_fail;

endmodule

// File: rtl/mem_ss_cal_sequencer.sv
// Memory-subsystem reset and EMIF calibration sequencer with ack/cal
// timeouts, bounded retry, loss-of-calibration detection and sticky status.
module mem_ss_cal_sequencer
    import mem_ss_cal_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter logic [NUM_CH-1:0] CH_MASK     = '1,
    parameter int                ACK_TIMEOUT = 1024,
    parameter int                CAL_TIMEOUT = 1048576,
    parameter int                STABLE_CYC  = 3,
    parameter int                MAX_RETRY   = 2,
    parameter int                AUTO_START  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_ss_rst_req,
    input  logic              mem_ss_rst_ack_n,
    input  logic [NUM_CH-1:0] cal_success,
    input  logic [NUM_CH-1:0] cal_fail,
    output logic [NUM_CH-1:0] cal_done_mask,
    output logic [NUM_CH-1:0] cal_fail_mask,
    output logic              busy,
    output logic              seq_done,
    output logic              seq_err,
    output logic [1:0]        err_code,
    output logic [1:0]        retry_cnt
);

    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam int CW = $clog2(CAL_TIMEOUT + 1);
    localparam logic [AW-1:0] ACK_LIM = AW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] CAL_LIM = CW'(CAL_TIMEOUT);

    t_cal_state        state, state_nxt;
    logic [AW-1:0]     ack_cnt, ack_cnt_nxt;
    logic [CW-1:0]     cal_cnt, cal_cnt_nxt;
    logic [1:0]        retry_q, retry_nxt;
    logic [1:0]        err_q, err_nxt;
    logic [NUM_CH-1:0] fmask_q, fmask_nxt;
    logic              auto_arm, arm_nxt;
    logic              flt_clr, flt_en;
    logic [NUM_CH-1:0] ch_done, ch_fail, lost;
    logic              all_done, cal_bad;
    t_cal_status       status;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mem_ss_cal_ch_filter #(
            .STABLE_CYC (STABLE_CYC),
            .IGNORE     (!CH_MASK[i])
        ) u_flt (
            .clk         (clk),
            .rst         (rst),
            .clr         (flt_clr),
            .en          (flt_en),
            .cal_success (cal_success[i]),
            .cal_fail    (cal_fail[i]),
            .done        (ch_done[i]),
            .fail        (ch_fail[i])
        );
    end

    assign all_done = &(ch_done | ~CH_MASK);
    assign lost     = CH_MASK & (~cal_success | cal_fail);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ack_cnt  <= '0;
            cal_cnt  <= '0;
            retry_q  <= '0;
            err_q    <= ERR_NONE;
            fmask_q  <= '0;
            auto_arm <= (AUTO_START != 0);
        end else begin
            state    <= state_nxt;
            ack_cnt  <= ack_cnt_nxt;
            cal_cnt  <= cal_cnt_nxt;
            retry_q  <= retry_nxt;
            err_q    <= err_nxt;
            fmask_q  <= fmask_nxt;
            auto_arm <= arm_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ack_cnt_nxt = ack_cnt;
        cal_cnt_nxt = cal_cnt;
        retry_nxt   = retry_q;
        err_nxt     = err_q;
        fmask_nxt   = fmask_q;
        arm_nxt     = auto_arm;
        flt_clr     = 1'b0;
        flt_en      = 1'b0;
        cal_bad     = 1'b0;
        unique case (state)
            S_IDLE, S_ERR: begin
                if (start || (state == S_IDLE && auto_arm)) begin
                    state_nxt   = S_RST_REQ;
                    ack_cnt_nxt = '0;
                    retry_nxt   = '0;
                    err_nxt     = ERR_NONE;
                    fmask_nxt   = '0;
                    arm_nxt     = 1'b0;
                    flt_clr     = 1'b1;
                end
            end
            S_RST_REQ: begin
                if (!mem_ss_rst_ack_n) begin
                    state_nxt   = S_WAIT_CAL;
                    cal_cnt_nxt = '0;
                    fmask_nxt   = '0;
                end else if (ack_cnt == ACK_LIM) begin
                    state_nxt = S_ERR;
                    err_nxt   = ERR_ACK;
                end else begin
                    ack_cnt_nxt = ack_cnt + AW'(1);
                end
            end
            S_WAIT_CAL: begin
                flt_en = 1'b1;
                // A failing channel outranks every done bit; done outranks timeout.
                if (|ch_fail) begin
                    fmask_nxt = ch_fail;
                    cal_bad   = 1'b1;
                end else if (all_done) begin
                    state_nxt = S_DONE;
                end else if (cal_cnt == CAL_LIM) begin
                    fmask_nxt = CH_MASK & ~ch_done;
                    cal_bad   = 1'b1;
                end else begin
                    cal_cnt_nxt = cal_cnt + CW'(1);
                end
                if (cal_bad) begin
                    if (int'(retry_q) < MAX_RETRY) begin
                        state_nxt = S_RETRY;
                    end else begin
                        state_nxt = S_ERR;
                        err_nxt   = ERR_CAL;
                    end
                end
            end
            S_RETRY: begin
                state_nxt   = S_RST_REQ;
                retry_nxt   = sat_inc2(retry_q);
                ack_cnt_nxt = '0;
                cal_cnt_nxt = '0;
                flt_clr     = 1'b1;
            end
            S_DONE: begin
                if (|lost) begin
                    state_nxt = S_ERR;
                    err_nxt   = ERR_LOST;
                    fmask_nxt = fmask_q | lost;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        status           = '0;
        status.busy      = (state == S_RST_REQ) ||
                           (state == S_WAIT_CAL) ||
                           (state == S_RETRY);
        status.seq_done  = (state == S_DONE);
        status.seq_err   = (state == S_ERR);
        status.err_code  = err_q;
        status.retry_cnt = retry_q;
    end

    assign mem_ss_rst_req = (state == S_RST_REQ);
    assign cal_done_mask  = ch_done;
    assign cal_fail_mask  = fmask_q;
    assign busy           = status.busy;
    assign seq_done       = status.seq_done;
    assign seq_err        = status.seq_err;
    assign err_code       = status.err_code;
    assign retry_cnt      = status.retry_cnt;

endmodule

// File: tb/tb_mem_ss_cal_sequencer.sv
// Directed bench for mem_ss_cal_sequencer: reset, ack timeout, retry,
// stability filter, masked channels, loss of calibration, mid-run reset.
module tb_mem_ss_cal_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ack_n = 1'b1;
    logic [3:0] succ = 4'hF;
    logic [3:0] fail = 4'h0;
    logic       rst_req;
    logic [3:0] done_mask, fail_mask;
    logic       busy, seq_done, seq_err;
    logic [1:0] err_code, retry_cnt;

    logic       start_m = 1'b0;
    logic       ack_n_m = 1'b1;
    logic [3:0] succ_m = 4'b1101;
    logic [3:0] fail_m = 4'h0;
    logic       rst_req_m;
    logic [3:0] done_mask_m, fail_mask_m;
    logic       busy_m, seq_done_m, seq_err_m;
    logic [1:0] err_code_m, retry_cnt_m;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_ss_cal_sequencer #(
        .NUM_CH(4), .CH_MASK(4'b1111), .ACK_TIMEOUT(64), .CAL_TIMEOUT(40),
        .STABLE_CYC(3), .MAX_RETRY(2), .AUTO_START(1)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_ss_rst_req(rst_req), .mem_ss_rst_ack_n(ack_n),
        .cal_success(succ), .cal_fail(fail),
        .cal_done_mask(done_mask), .cal_fail_mask(fail_mask),
        .busy(busy), .seq_done(seq_done), .seq_err(seq_err),
        .err_code(err_code), .retry_cnt(retry_cnt)
    );

    mem_ss_cal_sequencer #(
        .NUM_CH(4), .CH_MASK(4'b1101), .ACK_TIMEOUT(64), .CAL_TIMEOUT(40),
        .STABLE_CYC(3), .MAX_RETRY(2), .AUTO_START(0)
    ) u_dut_m (
        .clk(clk), .rst(rst), .start(start_m),
        .mem_ss_rst_req(rst_req_m), .mem_ss_rst_ack_n(ack_n_m),
        .cal_success(succ_m), .cal_fail(fail_m),
        .cal_done_mask(done_mask_m), .cal_fail_mask(fail_mask_m),
        .busy(busy_m), .seq_done(seq_done_m), .seq_err(seq_err_m),
        .err_code(err_code_m), .retry_cnt(retry_cnt_m)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (seq_done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (seq_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: seq_done got %b want 1 (timed out)", name, seq_done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rst_req, done_mask, fail_mask, busy, seq_done, seq_err, err_code, retry_cnt} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0000",
                {rst_req, done_mask, fail_mask, busy, seq_done, seq_err, err_code, retry_cnt});
        end
        n_checks++;
        if ({rst_req_m, busy_m, done_mask_m} !== 6'h0) begin
            n_fail++;
            $display("FAIL reset_masked_dut: got %h want 00", {rst_req_m, busy_m, done_mask_m});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int bad = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rst_req !== 1'b1) bad++;
            if (k == 10) ack_n = 1'b0;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL basic_rst_req_window: %0d low cycles in 1..10, want 0", bad);
        end
        @(negedge clk);
        ack_n = 1'b1;
        n_checks++;
        if (rst_req !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_req_drop: rst_req=%b busy=%b want 0/1", rst_req, busy);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_mask !== 4'hF || seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_mask: mask=%b done=%b want 1111/0", done_mask, seq_done);
        end
        @(negedge clk);
        n_checks++;
        if (seq_done !== 1'b1 || err_code !== 2'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_seq_done: done=%b err=%0d busy=%b want 1/0/0", seq_done, err_code, busy);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (seq_done !== 1'b1 || rst_req !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_start_dropped: done=%b rst_req=%b want 1/0", seq_done, rst_req);
        end
    endtask

    task automatic test_ack_timeout();
        int n = 0;
        do_reset();
        @(negedge clk);
        while (rst_req === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != 64) begin
            n_fail++;
            $display("FAIL ack_timeout_len: rst_req high %0d cycles want 64", n);
        end
        n_checks++;
        if (seq_err !== 1'b1 || err_code !== 2'd1 || retry_cnt !== 2'd0 || rst_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_timeout_err: err=%b code=%0d retry=%0d req=%b want 1/1/0/0",
                seq_err, err_code, retry_cnt, rst_req);
        end
    endtask

    task automatic test_retry();
        do_reset();
        @(negedge clk);
        ack_n = 1'b0;
        @(negedge clk);
        ack_n = 1'b1;
        fail = 4'b0100;
        @(negedge clk);
        fail = 4'b0000;
        n_checks++;
        if (busy !== 1'b1 || fail_mask !== 4'b0100 || retry_cnt !== 2'd0 || rst_req !== 1'b0) begin
            n_fail++;
            $display("FAIL retry_state: busy=%b fmask=%b retry=%0d req=%b want 1/0100/0/0",
                busy, fail_mask, retry_cnt, rst_req);
        end
        @(negedge clk);
        n_checks++;
        if (rst_req !== 1'b1 || retry_cnt !== 2'd1 || fail_mask !== 4'b0100) begin
            n_fail++;
            $display("FAIL retry_reissue: req=%b retry=%0d fmask=%b want 1/1/0100",
                rst_req, retry_cnt, fail_mask);
        end
        ack_n = 1'b0;
        @(negedge clk);
        ack_n = 1'b1;
        n_checks++;
        if (fail_mask !== 4'b0000) begin
            n_fail++;
            $display("FAIL retry_mask_clear: fmask=%b want 0000", fail_mask);
        end
        wait_done("retry_done");
        n_checks++;
        if (retry_cnt !== 2'd1 || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL retry_final: retry=%0d err=%0d want 1/0", retry_cnt, err_code);
        end
    endtask

    task automatic test_cal_timeout();
        int n = 0;
        int reqs = 0;
        do_reset();
        succ = 4'h0;
        @(negedge clk);
        while (seq_err !== 1'b1 && n < 1000) begin
            if (rst_req === 1'b1) reqs++;
            ack_n = ~rst_req;
            @(negedge clk);
            n++;
        end
        ack_n = 1'b1;
        succ = 4'hF;
        n_checks++;
        if (seq_err !== 1'b1 || err_code !== 2'd2 || retry_cnt !== 2'd2 || fail_mask !== 4'hF || reqs != 3) begin
            n_fail++;
            $display("FAIL cal_timeout: err=%b code=%0d retry=%0d fmask=%b reqs=%0d want 1/2/2/1111/3",
                seq_err, err_code, retry_cnt, fail_mask, reqs);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (rst_req !== 1'b1 || retry_cnt !== 2'd0 || err_code !== 2'd0 || fail_mask !== 4'h0) begin
            n_fail++;
            $display("FAIL err_restart: req=%b retry=%0d err=%0d fmask=%b want 1/0/0/0000",
                rst_req, retry_cnt, err_code, fail_mask);
        end
        ack_n = 1'b0;
        @(negedge clk);
        ack_n = 1'b1;
        wait_done("err_restart_done");
    endtask

    task automatic test_stability();
        logic [5:0] pat = 6'b111011;
        do_reset();
        succ = 4'b1101;
        @(negedge clk);
        ack_n = 1'b0;
        @(negedge clk);
        ack_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (j == 3) begin
                n_checks++;
                if (done_mask !== 4'b1101) begin
                    n_fail++;
                    $display("FAIL stab_partial: mask=%b want 1101", done_mask);
                end
            end
            if (j == 5) begin
                n_checks++;
                if (done_mask[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stab_early: done[1]=%b want 0", done_mask[1]);
                end
            end
            succ[1] = pat[j];
            if (j < 5) @(negedge clk);
        end
        @(negedge clk);
        n_checks++;
        if (done_mask !== 4'hF || seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL stab_set: mask=%b done=%b want 1111/0", done_mask, seq_done);
        end
        @(negedge clk);
        n_checks++;
        if (seq_done !== 1'b1) begin
            n_fail++;
            $display("FAIL stab_seq_done: done=%b want 1", seq_done);
        end
    endtask

    task automatic test_masked();
        int n = 0;
        n_checks++;
        if (busy_m !== 1'b0 || rst_req_m !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_idle: busy=%b req=%b want 0/0", busy_m, rst_req_m);
        end
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        ack_n_m = 1'b0;
        @(negedge clk);
        ack_n_m = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done_mask_m !== 4'b0010) begin
            n_fail++;
            $display("FAIL masked_bit: mask=%b want 0010", done_mask_m);
        end
        while (seq_done_m !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (seq_done_m !== 1'b1 || done_mask_m !== 4'hF || err_code_m !== 2'd0) begin
            n_fail++;
            $display("FAIL masked_done: done=%b mask=%b err=%0d want 1/1111/0",
                seq_done_m, done_mask_m, err_code_m);
        end
    endtask

    task automatic test_cal_lost();
        do_reset();
        succ = 4'hF;
        @(negedge clk);
        ack_n = 1'b0;
        @(negedge clk);
        ack_n = 1'b1;
        wait_done("lost_setup");
        succ[3] = 1'b0;
        @(negedge clk);
        succ[3] = 1'b1;
        n_checks++;
        if (seq_err !== 1'b1 || err_code !== 2'd3 || fail_mask !== 4'b1000 || done_mask !== 4'hF) begin
            n_fail++;
            $display("FAIL cal_lost: err=%b code=%0d fmask=%b dmask=%b want 1/3/1000/1111",
                seq_err, err_code, fail_mask, done_mask);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ack_n = 1'b0;
        @(negedge clk);
        ack_n = 1'b1;
        wait_done("lost_redo");
        n_checks++;
        if (err_code !== 2'd0 || retry_cnt !== 2'd0 || fail_mask !== 4'h0) begin
            n_fail++;
            $display("FAIL lost_redo_clean: err=%0d retry=%0d fmask=%b want 0/0/0000",
                err_code, retry_cnt, fail_mask);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        succ = 4'h0;
        @(negedge clk);
        ack_n = 1'b0;
        @(negedge clk);
        ack_n = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rst_req, done_mask, fail_mask, busy, seq_done, seq_err, err_code, retry_cnt} !== 16'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h want 0000",
                {rst_req, done_mask, fail_mask, busy, seq_done, seq_err, err_code, retry_cnt});
        end
        rst = 1'b0;
        succ = 4'hF;
        @(negedge clk);
        n_checks++;
        if (rst_req !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_autostart: req=%b busy=%b want 1/1", rst_req, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack_timeout();
        test_retry();
        test_cal_timeout();
        test_stability();
        test_masked();
        test_cal_lost();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
